// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph encodings, the shadow
// register layout and the BCD-to-segment conversion used by the display scanner.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-low.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // digit[3] is the leftmost (tens of minutes), digit[0] the rightmost.
    typedef struct packed {
        logic [3:0][3:0] digit;
        logic [3:0]      blink_mask;
        logic            lz_en;
        logic            colon_en;
        logic            colon_blink;
    } shadow_t;

    function automatic logic [6:0] bcd_to_seg(logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_scan_if.sv
// Digit-source to display-driver bundle: four BCD digits plus display controls
// in, multiplexed anode/segment/decimal-point drive out.
interface seg_display_scan_if;

    logic [3:0] tenmin;
    logic [3:0] onemin;
    logic [3:0] tensec;
    logic [3:0] onesec;
    logic [3:0] blink_mask;
    logic       lz_en;
    logic       colon_en;
    logic       colon_blink;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output tenmin, onemin, tensec, onesec, blink_mask, lz_en, colon_en, colon_blink,
        input  an, seg, dp
    );

    modport slave (
        input  tenmin, onemin, tensec, onesec, blink_mask, lz_en, colon_en, colon_blink,
        output an, seg, dp
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 show a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit common-anode scanner: per-slot anti-ghost blanking, blink, leading-zero
// suppression and colon, all driven from a once-per-frame shadow copy of the inputs.
module seg_display_scan
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned GHOST_CYCLES = 16,
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input  logic               clk100MHz,
    input  logic               rst,
    seg_display_scan_if.slave  bus
);

    localparam int unsigned CNT_W   = $clog2(DIGIT_CYCLES);
    localparam int unsigned BLINK_W = $clog2(BLINK_CYCLES);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   GHOST_END  = CNT_W'(GHOST_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         slot_q, slot_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    shadow_t            shadow_q, shadow_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               cnt_wrap;
    logic               blink_wrap;
    logic [3:0]         cur_digit;
    logic [6:0]         dec_seg;
    logic               blank;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        shadow_d = shadow_q;

        cnt_wrap      = (cnt_q == CNT_LAST);
        cnt_d         = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        slot_d        = cnt_wrap ? slot_q + 2'd1 : slot_q;

        blink_wrap    = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q ^ blink_wrap;

        // Capture on the last cycle of slot 3 so a whole frame renders one coherent time.
        if (cnt_wrap && (slot_q == 2'd3)) begin
            shadow_d.digit       = {bus.tenmin, bus.onemin, bus.tensec, bus.onesec};
            shadow_d.blink_mask  = bus.blink_mask;
            shadow_d.lz_en       = bus.lz_en;
            shadow_d.colon_en    = bus.colon_en;
            shadow_d.colon_blink = bus.colon_blink;
        end
    end

    assign cur_digit = shadow_q.digit[slot_q];

    seg7_decode u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_comb begin
        blank = (shadow_q.blink_mask[slot_q] && blink_phase_q) ||
                ((slot_q == 2'd3) && shadow_q.lz_en && (cur_digit == 4'd0));
        seg_d = blank ? SEG_BLANK : dec_seg;
        // One-hot-low anode by construction, so two digits can never be lit together.
        an_d  = (cnt_q < GHOST_END) ? 4'hF : ~(4'b0001 << slot_q);
        dp_d  = !((slot_q == 2'd2) && shadow_q.colon_en &&
                  !(shadow_q.colon_blink && blink_phase_q));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk100MHz or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            slot_q        <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            shadow_q      <= '0;
            an_q          <= 4'hF;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            cnt_q         <= cnt_d;
            slot_q        <= slot_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            shadow_q      <= shadow_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan: directed scenarios plus random inputs,
// compared every cycle against a cycle-count based reference of the display.
module tb_seg_display_scan;

    localparam int DC    = 8;
    localparam int GC    = 2;
    localparam int BC    = 64;
    localparam int FRAME = 4 * DC;

    localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic clk100MHz = 1'b0;
    logic rst       = 1'b1;

    always #5 clk100MHz = ~clk100MHz;

    seg_display_scan_if bus ();

    seg_display_scan #(
        .DIGIT_CYCLES (DC),
        .GHOST_CYCLES (GC),
        .BLINK_CYCLES (BC)
    ) dut (
        .clk100MHz (clk100MHz),
        .rst       (rst),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: n = clock edges since reset release; shadow = last frame capture.
    int         n = 0;
    logic [3:0] sh_dig [4];
    logic [3:0] sh_mask;
    logic       sh_lz, sh_ce, sh_cb;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    function automatic logic [6:0] glyph_of(input logic [3:0] v);
        if (v > 4'd9) return 7'h3F;
        return GLYPH[int'(v)];
    endfunction

    task automatic model_clear();
        n = 0;
        for (int i = 0; i < 4; i++) sh_dig[i] = 4'd0;
        sh_mask = 4'd0;
        sh_lz   = 1'b0;
        sh_ce   = 1'b0;
        sh_cb   = 1'b0;
    endtask

    task automatic set_inputs(input logic [3:0] tm, input logic [3:0] om, input logic [3:0] ts,
                              input logic [3:0] os, input logic [3:0] mask, input logic lz,
                              input logic ce, input logic cb);
        bus.tenmin      = tm;
        bus.onemin      = om;
        bus.tensec      = ts;
        bus.onesec      = os;
        bus.blink_mask  = mask;
        bus.lz_en       = lz;
        bus.colon_en    = ce;
        bus.colon_blink = cb;
    endtask

    // Advance one clock; the outputs after the edge must show display state n.
    task automatic cycle();
        int         slot, cnt, ph;
        logic [3:0] val, e_an;
        logic [6:0] e_seg;
        logic       e_dp, blank;
        slot  = (n / DC) % 4;
        cnt   = n % DC;
        ph    = (n / BC) % 2;
        val   = sh_dig[slot];
        e_an  = (cnt < GC) ? 4'hF : (4'hF & ~(4'b0001 << slot));
        blank = (sh_mask[slot] && ph == 1) || (slot == 3 && sh_lz && val == 4'd0);
        e_seg = blank ? 7'h7F : glyph_of(val);
        e_dp  = !(slot == 2 && sh_ce && !(sh_cb && ph == 1));
        if (n % FRAME == FRAME - 1) begin
            sh_dig[3] = bus.tenmin;
            sh_dig[2] = bus.onemin;
            sh_dig[1] = bus.tensec;
            sh_dig[0] = bus.onesec;
            sh_mask   = bus.blink_mask;
            sh_lz     = bus.lz_en;
            sh_ce     = bus.colon_en;
            sh_cb     = bus.colon_blink;
        end
        @(posedge clk100MHz);
        #1;
        check("an", 12'(bus.an), 12'(e_an));
        check("seg", 12'(bus.seg), 12'(e_seg));
        check("dp", 12'(bus.dp), 12'(e_dp));
        n++;
    endtask

    // Afterwards the outputs reflect display state idx.
    task automatic run_to(input int idx);
        while (n <= idx) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_inputs(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        model_clear();

        // Reset and scan
        #2 rst = 1'b0;
        #1;
        check("rst_an", 12'(bus.an), 12'h00F);
        check("rst_seg", 12'(bus.seg), 12'h07F);
        check("rst_dp", 12'(bus.dp), 12'h001);
        repeat (3) @(posedge clk100MHz);
        #1;
        check("rst_hold_an", 12'(bus.an), 12'h00F);
        @(negedge clk100MHz);
        rst = 1'b1;
        model_clear();

        run_to(0);
        check("scan_ghost0", 12'(bus.an), 12'h00F);
        run_to(4);
        check("scan_slot0_an", 12'(bus.an), 12'h00E);
        check("scan_slot0_seg", 12'(bus.seg), 12'h040);

        // Capture boundary: new digits mid-frame stay invisible until the next frame
        run_to(11);
        set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0);
        run_to(28);
        check("cap_old_frame_d3", 12'(bus.seg), 12'h040);
        run_to(FRAME + 4);
        check("cap_d0", 12'(bus.seg), 12'h019);
        run_to(FRAME + 12);
        check("cap_d1", 12'(bus.seg), 12'h030);
        run_to(FRAME + 20);
        check("cap_d2", 12'(bus.seg), 12'h024);
        run_to(FRAME + 28);
        check("cap_d3", 12'(bus.seg), 12'h079);

        // Leading-zero blanking, then invalid BCD dash
        run_to(2 * FRAME + 10);
        set_inputs(4'd0, 4'd2, 4'd3, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0);
        run_to(3 * FRAME + 28);
        check("lz_blank_d3", 12'(bus.seg), 12'h07F);
        run_to(3 * FRAME + 5);
        set_inputs(4'hC, 4'd2, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0);
        run_to(4 * FRAME + 28);
        check("dash_d3", 12'(bus.seg), 12'h03F);

        // Blink on digits 0/1 and the colon
        set_inputs(4'hC, 4'd2, 4'd3, 4'd4, 4'b0011, 1'b0, 1'b1, 1'b1);
        run_to(5 * FRAME + 4);
        check("blink_lit_d0", 12'(bus.seg), 12'h019);
        run_to(5 * FRAME + 20);
        check("blink_lit_dp", 12'(bus.dp), 12'h000);
        run_to(6 * FRAME + 4);
        check("blink_off_d0", 12'(bus.seg), 12'h07F);
        run_to(6 * FRAME + 12);
        check("blink_off_d1", 12'(bus.seg), 12'h07F);
        run_to(6 * FRAME + 20);
        check("blink_off_d2_lit", 12'(bus.seg), 12'h024);
        check("blink_off_dp", 12'(bus.dp), 12'h001);
        run_to(6 * FRAME + 28);
        check("blink_off_d3_lit", 12'(bus.seg), 12'h03F);
        run_to(8 * FRAME + 12);
        check("blink_relit_d1", 12'(bus.seg), 12'h030);

        // Random inputs, changed at a random point in each frame (capture cycle included)
        for (int f = 9; f < 39; f++) begin
            int k;
            k = $urandom_range(0, FRAME - 1);
            run_to(f * FRAME + k - 1);
            set_inputs(($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
            run_to(f * FRAME + FRAME - 1);
        end

        // Reset during slot 2's active window
        run_to(40 * FRAME + 2 * DC + 4);
        check("pre_rst_an", 12'(bus.an), 12'h00B);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_an", 12'(bus.an), 12'h00F);
        check("mid_rst_seg", 12'(bus.seg), 12'h07F);
        check("mid_rst_dp", 12'(bus.dp), 12'h001);
        @(posedge clk100MHz);
        #1;
        check("mid_rst_hold_an", 12'(bus.an), 12'h00F);
        @(negedge clk100MHz);
        rst = 1'b1;
        model_clear();
        set_inputs(4'd9, 4'd8, 4'd7, 4'd6, 4'hF, 1'b0, 1'b1, 1'b0);
        run_to(4);
        check("post_rst_slot0_an", 12'(bus.an), 12'h00E);
        check("post_rst_slot0_seg", 12'(bus.seg), 12'h040);
        run_to(FRAME + 4);
        check("post_rst_phase0_d0", 12'(bus.seg), 12'h002);
        run_to(2 * FRAME + 4);
        check("post_rst_phase1_d0", 12'(bus.seg), 12'h07F);
        run_to(4 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seg_display_scan.md
# seg_display_scan

- Time-multiplexed driver for the board's 4-digit common-anode seven-segment display.
- Sits directly downstream of the timer/clock digit sources and consumes their four BCD digit outputs (tens-minutes, ones-minutes, tens-seconds, ones-seconds).
- Scans one digit at a time with anti-ghosting blank slots, per-digit blink, leading-zero blanking, an invalid-BCD glyph and a colon on the decimal point.
- Samples the digit inputs once per frame, so a display frame never shows a half-updated time.

## Interface
Parameters:
- DIGIT_CYCLES, 100000: clock cycles per digit slot (1 ms at 100 MHz); minimum GHOST_CYCLES+2.
- GHOST_CYCLES, 16: cycles at the start of each slot during which all anodes are off; minimum 1.
- BLINK_CYCLES, 25000000: half-period of the blink phase (0.25 s); minimum 2.

Ports:
- clk100MHz  in  1  system clock, all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- tenmin  in  4  BCD digit 3 (leftmost).
- onemin  in  4  BCD digit 2.
- tensec  in  4  BCD digit 1.
- onesec  in  4  BCD digit 0 (rightmost).
- blink_mask  in  4  bit i set: digit i is blanked while blink_phase=1.
- lz_en  in  1  blank digit 3 when its value is 0.
- colon_en  in  1  light the dp of digit 2.
- colon_blink  in  1  colon follows blink_phase (off when phase=1).
- an  out  4  anode enables, active-low, bit i = digit i.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- cnt counts 0..DIGIT_CYCLES-1 and wraps. On wrap, slot increments 0→1→2→3→0.
- blink_cnt counts 0..BLINK_CYCLES-1. On wrap, blink_phase toggles. It is free-running and independent of slot.
- Shadow capture: in the cycle where slot=3 and cnt=DIGIT_CYCLES-1, the four digits, blink_mask, lz_en, colon_en and colon_blink load into shadow registers. All display decisions use the shadow values only.
- A digit is blank (seg=7'h7F) if any of the following holds:
  - blink_mask_s[slot] and blink_phase;
  - slot=3, lz_en_s and tenmin_s=0.
- Decode (active-low), for values 0..9: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10.
- Values 10..15 display the dash 7'h3F (segment g only).
- dp=0 only when slot=2, colon_en_s=1, and not (colon_blink_s and blink_phase). Otherwise dp=1.
- Ghost window: while cnt<GHOST_CYCLES, an=4'hF. seg and dp still carry the current slot's value.
- Active window: an = ~(1<<slot).

## Timing
- an, seg and dp are registered and reflect the cnt/slot/shadow state of the previous cycle (1-cycle latency).
- Per slot, an[slot]=0 for exactly DIGIT_CYCLES-GHOST_CYCLES consecutive cycles, followed by GHOST_CYCLES cycles of an=4'hF.
- Frame period is 4*DIGIT_CYCLES.
- Input-to-display latency is at most 4*DIGIT_CYCLES+2 cycles. An input change in the capture cycle itself is captured.
- Reset asserted, asynchronously:
  - an=4'hF, seg=7'h7F, dp=1;
  - cnt=0, slot=0, blink_cnt=0, blink_phase=0;
  - all shadow registers=0.
- After rst deasserts, the first frame shows shadow zeros, rendered as "0000" with lz_en_s=0 from reset. Real inputs appear from the second frame.
- Reset mid-slot: the display goes dark immediately, with no partial slot afterward.
- Two anodes are never low in the same cycle.
- Blink and capture in the same cycle: the toggle and the capture both take effect; the next output uses the new phase and the new shadow.

## Structure
- Package seg7_pkg holds:
  - the ten digit encodings, SEG_BLANK=7'h7F and SEG_DASH=7'h3F;
  - the function bcd_to_seg(logic [3:0]) returning logic [6:0].
- One sub-module, seg7_decode: purely combinational, BCD in, segments out, wrapping bcd_to_seg. The slot mux feeds it.
- The scan counter, blink counter, shadow registers and output registers stay in the top module.

## Test plan
All tests use DIGIT_CYCLES=8, GHOST_CYCLES=2, BLINK_CYCLES=64.
- Reset and scan: hold rst low, then release. Required:
  - an=4'hF while reset is held;
  - afterwards an cycles 4'hE, 4'hD, 4'hB, 4'h7, each low for 6 cycles and separated by 2 cycles of 4'hF;
  - seg=7'h40 on every slot.
- Capture boundary: inputs 1,2,3,4 (tenmin..onesec) applied mid-frame. Required:
  - the current frame still shows zeros;
  - the next frame shows digit0=7'h19, digit1=7'h30, digit2=7'h24, digit3=7'h79.
- Blanking and invalid: tenmin=0 with lz_en=1 gives digit3 seg=7'h7F. tenmin=4'hC with lz_en=0 gives 7'h3F.
- Blink: blink_mask=4'b0011 with colon_en=1 and colon_blink=1. Required:
  - digits 0 and 1 plus dp on digit 2 alternate lit/blank every 64 cycles;
  - digits 2 and 3 stay lit.
- Mid-operation reset: pull rst low during slot 2's active window. Required:
  - an=4'hF in the same cycle;
  - after release, slot restarts at 0 with blink_phase=0.
